axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator that converts a simple command/response request port into AXI4-Lite read and write transactions.
- Drives the timer register block and any other AXI4-Lite responder in the design from firmware-less test sequencers or local control FSMs.
- Includes a response watchdog that flags responders that never answer.

Parameters:
AXI_ADDR_BW_p, 12, AXI address width
TIMEOUT_CYCLES_p, 1024, cycles of waiting on a response before o_timeout asserts; 0 disables the watchdog

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
i_cmd_valid  input  1  command request
o_cmd_ready  output  1  command accepted when high together with i_cmd_valid
i_cmd_write  input  1  1=write, 0=read
i_cmd_addr  input  AXI_ADDR_BW_p  byte address
i_cmd_wdata  input  32  write data
i_cmd_wstrb  input  4  write byte strobes
o_rsp_valid  output  1  response available
i_rsp_ready  input  1  response consumed
o_rsp_rdata  output  32  read data; 0 for writes
o_rsp_resp  output  2  BRESP or RRESP
o_rsp_write  output  1  response belongs to a write
o_timeout  output  1  watchdog expired on the current transaction
o_axi_awaddr  output  AXI_ADDR_BW_p  write address
o_axi_awvalid  output  1  write address valid
i_axi_awready  input  1  write address ready
o_axi_wdata  output  32  write data
o_axi_wstrb  output  4  write strobes
o_axi_wvalid  output  1  write data valid
i_axi_wready  input  1  write data ready
i_axi_bresp  input  2  write response
i_axi_bvalid  input  1  write response valid
o_axi_bready  output  1  write response ready
o_axi_araddr  output  AXI_ADDR_BW_p  read address
o_axi_arvalid  output  1  read address valid
i_axi_arready  input  1  read address ready
i_axi_rdata  input  32  read data
i_axi_rresp  input  2  read response
i_axi_rvalid  input  1  read data valid
o_axi_rready  output  1  read data ready

Behaviour:
- Reset: all outputs 0 except o_cmd_ready=1 in IDLE; state=IDLE; watchdog counter=0. Reset mid-transaction drops all valids immediately. The responder is reset by the same rst_n.
- States:
  - IDLE: o_cmd_ready=1. A command handshake latches addr/wdata/wstrb and goes to WRITE if i_cmd_write=1, otherwise READ.
  - WRITE: awvalid and wvalid asserted from the next cycle. Each deasserts independently after its own handshake; both may complete in the same or different cycles. bready=1 throughout WRITE. On the B handshake, capture bresp and go to RSP. A bvalid arriving before both AW and W have completed is a protocol violation: do not capture it; bready stays high.
  - READ: arvalid asserted until the AR handshake; rready=1 throughout READ. On the R handshake, capture rdata and rresp and go to RSP.
  - RSP: o_rsp_valid=1 with the captured data held stable. On i_rsp_ready, return to IDLE.
- Single outstanding transaction only; o_cmd_ready=0 in all states except IDLE.
- Valids never deassert before their handshake. AXI outputs are registered. Addr/data are held stable while valid.
- Latency against a zero-wait responder that registers its response:
  - command handshake at cycle T;
  - AW/W (or AR) handshake at T+1;
  - B/R handshake at T+2;
  - o_rsp_valid at T+3.
- Response data: o_rsp_rdata=0 for writes. o_rsp_resp carries the raw 2-bit value, SLVERR/DECERR passed through unchanged.
- Watchdog:
  - Counter clears on command accept and increments each cycle in WRITE or READ.
  - At count==TIMEOUT_CYCLES_p, o_timeout=1 and stays high; the counter saturates.
  - The transaction is NOT aborted; the FSM keeps waiting.
  - o_timeout clears when the FSM returns to IDLE.
- Simultaneous events: a response handshake in the same cycle as the last address handshake is legal only for reads after AR. For writes, B is accepted only in a cycle after both AW and W are done.

Test Plan:
- Write 0x4 data 0x0000_1234, strb 0xF to axi_timer → o_cnt0_load_value=0x1234; rsp_valid at T+3 with resp=00, o_rsp_write=1.
- Read 0x4 after the previous write → o_rsp_rdata=0x0000_1234, resp=00; read 0xC with i_cnt0_value=0xABCD → rdata=0xABCD.
- Read 0x40 (unmapped) → resp=10, rdata=0xDEADDEAD; write 0x40 → resp=10.
- Responder model with awready delayed 3 cycles and wready immediate → wvalid drops after 1 cycle, awvalid held 3 cycles with stable addr, exactly one B accepted.
- Hold i_rsp_ready=0 for 5 cycles in RSP → o_rsp_* stable, o_cmd_ready=0, no new AXI valids; back-to-back commands after release are each issued one at a time.
- TIMEOUT_CYCLES_p=8, responder never asserts rvalid → o_timeout=1 at the 8th wait cycle. rvalid then given → response delivered and o_timeout=0 on return to IDLE. Reset asserted mid-WRITE → all valids 0 the next cycle.

Source files
------------

// File: rtl/axi_lite_master_if.sv
// ============================================================================
//  Module   : axi_lite_master_if
//  Purpose  : AXI4-Lite bus bundle with initiator and responder views.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface axi_lite_master_if #(
    parameter int AXI_ADDR_BW_p = 12
);
    logic [AXI_ADDR_BW_p-1:0] awaddr;
    logic                     awvalid;
    logic                     awready;
    logic [31:0]              wdata;
    logic [3:0]               wstrb;
    logic                     wvalid;
    logic                     wready;
    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;
    logic [AXI_ADDR_BW_p-1:0] araddr;
    logic                     arvalid;
    logic                     arready;
    logic [31:0]              rdata;
    logic [1:0]               rresp;
    logic                     rvalid;
    logic                     rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

`default_nettype wire

// File: rtl/axi_lite_master.sv
// ============================================================================
//  Module   : axi_lite_master
//  Purpose  : Single-outstanding AXI4-Lite initiator with response watchdog.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_lite_master #(
    parameter int AXI_ADDR_BW_p    = 12,
    parameter int TIMEOUT_CYCLES_p = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_write,
    input  logic [AXI_ADDR_BW_p-1:0] i_cmd_addr,
    input  logic [31:0]              i_cmd_wdata,
    input  logic [3:0]               i_cmd_wstrb,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [31:0]              o_rsp_rdata,
    output logic [1:0]               o_rsp_resp,
    output logic                     o_rsp_write,
    output logic                     o_timeout,
    axi_lite_master_if.master        axi
);

    localparam int                 c_WD_BW    = (TIMEOUT_CYCLES_p > 0) ? $clog2(TIMEOUT_CYCLES_p + 1) : 1;
    localparam logic [c_WD_BW-1:0] c_WD_LIMIT = c_WD_BW'(TIMEOUT_CYCLES_p);
    localparam logic               c_WD_EN    = (TIMEOUT_CYCLES_p > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RSP   = 2'd3
    } state_t;

    state_t                   state_q;
    logic                     cmd_ready_q;
    logic                     awvalid_q;
    logic                     wvalid_q;
    logic                     bready_q;
    logic                     arvalid_q;
    logic                     rready_q;
    logic [AXI_ADDR_BW_p-1:0] addr_q;
    logic [31:0]              wdata_q;
    logic [3:0]               wstrb_q;
    logic                     rsp_valid_q;
    logic [31:0]              rsp_rdata_q;
    logic [1:0]               rsp_resp_q;
    logic                     rsp_write_q;
    logic [c_WD_BW-1:0]       wd_cnt_q;
    logic                     timeout_q;

    logic w_cmd_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_b_hs;
    logic w_r_hs;
    logic w_wd_tick;

    assign w_cmd_hs  = i_cmd_valid && cmd_ready_q;
    assign w_aw_hs   = awvalid_q && axi.awready;
    assign w_w_hs    = wvalid_q && axi.wready;
    assign w_ar_hs   = arvalid_q && axi.arready;
    // A B response is only taken once both AW and W completed in earlier cycles.
    assign w_b_hs    = (state_q == S_WRITE) && !awvalid_q && !wvalid_q && axi.bvalid;
    assign w_r_hs    = (state_q == S_READ) && (!arvalid_q || axi.arready) && axi.rvalid;
    assign w_wd_tick = c_WD_EN && ((state_q == S_WRITE) || (state_q == S_READ))
                       && (wd_cnt_q != c_WD_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rsp_write_q <= 1'b0;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            // The watchdog only flags; the transaction keeps waiting.
            if (w_wd_tick) begin
                wd_cnt_q <= wd_cnt_q + c_WD_BW'(1);
                if ((wd_cnt_q + c_WD_BW'(1)) == c_WD_LIMIT) begin
                    timeout_q <= 1'b1;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (w_cmd_hs) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= i_cmd_addr;
                        wdata_q     <= i_cmd_wdata;
                        wstrb_q     <= i_cmd_wstrb;
                        wd_cnt_q    <= '0;
                        timeout_q   <= 1'b0;
                        if (i_cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            bready_q  <= 1'b1;
                            state_q   <= S_WRITE;
                        end else begin
                            arvalid_q <= 1'b1;
                            rready_q  <= 1'b1;
                            state_q   <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_aw_hs) awvalid_q <= 1'b0;
                    if (w_w_hs)  wvalid_q  <= 1'b0;
                    if (w_b_hs) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= axi.bresp;
                        rsp_write_q <= 1'b1;
                        state_q     <= S_RSP;
                    end
                end
                S_READ: begin
                    if (w_ar_hs) arvalid_q <= 1'b0;
                    if (w_r_hs) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= axi.rdata;
                        rsp_resp_q  <= axi.rresp;
                        rsp_write_q <= 1'b0;
                        state_q     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        timeout_q   <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_resp  = rsp_resp_q;
    assign o_rsp_write = rsp_write_q;
    assign o_timeout   = timeout_q;

    assign axi.awaddr  = addr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = addr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_master.sv
// ============================================================================
//  Module   : tb_axi_lite_master
//  Purpose  : Self-checking bench: register-file responder, transaction model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_master;

    localparam int ABW = 12;
    localparam int TO  = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cmd_valid, cmd_ready, cmd_write;
    logic [ABW-1:0] cmd_addr;
    logic [31:0]    cmd_wdata;
    logic [3:0]     cmd_wstrb;
    logic           rsp_valid, rsp_ready, rsp_write, timeout_o;
    logic [31:0]    rsp_rdata;
    logic [1:0]     rsp_resp;

    always #5 clk = ~clk;

    axi_lite_master_if #(.AXI_ADDR_BW_p(ABW)) bus ();

    axi_lite_master #(.AXI_ADDR_BW_p(ABW), .TIMEOUT_CYCLES_p(TO)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rsp_resp(rsp_resp), .o_rsp_write(rsp_write), .o_timeout(timeout_o),
        .axi(bus.master)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic mapped(input logic [ABW-1:0] a);
        return a < 12'h040;
    endfunction

    // ---------------- responder: 16-word register file, 0x40+ unmapped ----
    int          aw_delay = 0;
    logic        r_hold   = 1'b0;
    int          aw_cnt;
    int          b_count;
    logic        aw_got, w_got, ar_got;
    logic [31:0] rsp_mem [16];

    assign bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
    assign bus.wready  = bus.wvalid;
    assign bus.arready = bus.arvalid;

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_cnt <= 0; b_count <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
            bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= 32'h0;
            for (int i = 0; i < 16; i++) rsp_mem[i] <= (i == 3) ? 32'h0000_ABCD : 32'h0;
        end else begin
            if (bus.awvalid && !bus.awready) aw_cnt <= aw_cnt + 1;
            if (bus.awvalid && bus.awready) begin aw_cnt <= 0; aw_got <= 1'b1; end
            if (bus.wvalid && bus.wready) w_got <= 1'b1;
            if (!bus.bvalid && (aw_got || (bus.awvalid && bus.awready))
                            && (w_got || (bus.wvalid && bus.wready))) begin
                bus.bvalid <= 1'b1;
                bus.bresp  <= mapped(bus.awaddr) ? 2'b00 : 2'b10;
            end
            if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
                b_count    <= b_count + 1;
                if (mapped(bus.awaddr))
                    rsp_mem[bus.awaddr[5:2]] <= merge(rsp_mem[bus.awaddr[5:2]], bus.wdata, bus.wstrb);
            end
            if (bus.arvalid && bus.arready) ar_got <= 1'b1;
            if ((ar_got || (bus.arvalid && bus.arready)) && !bus.rvalid && !r_hold) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= mapped(bus.araddr) ? rsp_mem[bus.araddr[5:2]] : 32'hDEAD_DEAD;
                bus.rresp  <= mapped(bus.araddr) ? 2'b00 : 2'b10;
                ar_got     <= 1'b0;
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
        end
    end

    // ---------------- transaction model and per-cycle compare ------------
    typedef struct packed { logic w; logic [31:0] rdata; logic [1:0] resp; } exp_t;
    exp_t        expq [$];
    exp_t        e;
    logic [31:0] ref_mem [16];
    int          inflight, n_awcyc, n_wcyc;
    logic        p_aw_v, p_aw_r, p_w_v, p_w_r, p_ar_v, p_ar_r, p_rsp_v, p_rsp_r, p_rw;
    logic [ABW-1:0] p_awaddr, p_araddr;
    logic [31:0] p_wdata, p_rdata;
    logic [3:0]  p_wstrb;
    logic [1:0]  p_resp;

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            inflight = 0;
            p_aw_v = 1'b0; p_w_v = 1'b0; p_ar_v = 1'b0; p_rsp_v = 1'b0;
            for (int i = 0; i < 16; i++) ref_mem[i] = (i == 3) ? 32'h0000_ABCD : 32'h0;
        end else begin
            if (bus.awvalid) n_awcyc++;
            if (bus.wvalid)  n_wcyc++;
            if (cmd_ready) begin
                chk("idle_quiet", 64'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready,
                                       bus.rready, rsp_valid, timeout_o}), 64'd0);
                chk("single_outstanding", 64'(inflight), 64'd0);
            end
            if (p_aw_v && !p_aw_r)
                chk("aw_stable", 64'({bus.awvalid, bus.awaddr}), 64'({1'b1, p_awaddr}));
            if (p_w_v && !p_w_r)
                chk("w_stable", 64'({bus.wvalid, bus.wstrb, bus.wdata}), 64'({1'b1, p_wstrb, p_wdata}));
            if (p_ar_v && !p_ar_r)
                chk("ar_stable", 64'({bus.arvalid, bus.araddr}), 64'({1'b1, p_araddr}));
            if (p_rsp_v && !p_rsp_r)
                chk("rsp_stable", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}),
                    64'({1'b1, p_rw, p_resp, p_rdata}));
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", 64'(expq.size()), 64'd1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    chk("rsp_resp",  64'(rsp_resp),  64'(e.resp));
                    chk("rsp_write", 64'(rsp_write), 64'(e.w));
                    inflight--;
                end
            end
            if (cmd_valid && cmd_ready) begin
                e.w    = cmd_write;
                e.resp = mapped(cmd_addr) ? 2'b00 : 2'b10;
                if (cmd_write) begin
                    e.rdata = 32'h0;
                    if (mapped(cmd_addr))
                        ref_mem[cmd_addr[5:2]] = merge(ref_mem[cmd_addr[5:2]], cmd_wdata, cmd_wstrb);
                end else begin
                    e.rdata = mapped(cmd_addr) ? ref_mem[cmd_addr[5:2]] : 32'hDEAD_DEAD;
                end
                expq.push_back(e);
                inflight++;
            end
            p_aw_v = bus.awvalid; p_aw_r = bus.awready; p_awaddr = bus.awaddr;
            p_w_v  = bus.wvalid;  p_w_r  = bus.wready;  p_wdata  = bus.wdata; p_wstrb = bus.wstrb;
            p_ar_v = bus.arvalid; p_ar_r = bus.arready; p_araddr = bus.araddr;
            p_rsp_v = rsp_valid;  p_rsp_r = rsp_ready;  p_rdata  = rsp_rdata;
            p_resp  = rsp_resp;   p_rw    = rsp_write;
        end
    end

    // ---------------- directed stimulus ----------------------------------
    task automatic run_cmd(input logic w, input logic [ABW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int hold, output int lat,
                           output logic [31:0] rd, output logic [1:0] rr, output logic rw);
        int budget = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        rsp_ready = (hold == 0);
        @(negedge clk);
        while (!cmd_ready && budget < 100) begin @(negedge clk); budget++; end
        chk("cmd_accept_wait", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 200);
        chk("rsp_wait", 64'(rsp_valid), 64'd1);
        rd = rsp_rdata; rr = rsp_resp; rw = rsp_write;
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                chk("hold_quiet", 64'({cmd_ready, bus.awvalid, bus.wvalid, bus.arvalid, rsp_valid}),
                    64'd1);
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    int          lat, bc0, k;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        rw;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
        n_awcyc = 0; n_wcyc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_axi_valids", 64'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata, timeout_o}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_cmd(1'b1, 12'h004, 32'h0000_1234, 4'hF, 0, lat, rd, rr, rw);
        chk("wr4_latency", 64'(lat), 64'd3);
        chk("wr4_resp", 64'({rw, rr, rd}), 64'({1'b1, 2'b00, 32'h0}));
        chk("wr4_reg", 64'(rsp_mem[1]), 64'h1234);

        run_cmd(1'b0, 12'h004, 32'h0, 4'h0, 0, lat, rd, rr, rw);
        chk("rd4_latency", 64'(lat), 64'd3);
        chk("rd4_data", 64'({rw, rr, rd}), 64'({1'b0, 2'b00, 32'h0000_1234}));
        run_cmd(1'b0, 12'h00C, 32'h0, 4'h0, 0, lat, rd, rr, rw);
        chk("rdC_data", 64'(rd), 64'h0000_ABCD);

        run_cmd(1'b0, 12'h040, 32'h0, 4'h0, 0, lat, rd, rr, rw);
        chk("rd40_unmapped", 64'({rr, rd}), 64'({2'b10, 32'hDEAD_DEAD}));
        run_cmd(1'b1, 12'h040, 32'h5555_5555, 4'hF, 0, lat, rd, rr, rw);
        chk("wr40_unmapped", 64'({rw, rr, rd}), 64'({1'b1, 2'b10, 32'h0}));

        n_awcyc = 0; n_wcyc = 0; bc0 = b_count; aw_delay = 2;
        run_cmd(1'b1, 12'h008, 32'h55AA_1122, 4'hC, 0, lat, rd, rr, rw);
        chk("awdly_aw_cycles", 64'(n_awcyc), 64'd3);
        chk("awdly_w_cycles", 64'(n_wcyc), 64'd1);
        chk("awdly_one_b", 64'(b_count - bc0), 64'd1);
        chk("awdly_latency", 64'(lat), 64'd5);
        aw_delay = 0;

        run_cmd(1'b0, 12'h008, 32'h0, 4'h0, 5, lat, rd, rr, rw);
        chk("hold_rd8_data", 64'(rd), 64'h55AA_0000);
        run_cmd(1'b1, 12'h010, 32'hCAFE_F00D, 4'h3, 0, lat, rd, rr, rw);
        run_cmd(1'b0, 12'h010, 32'h0, 4'h0, 0, lat, rd, rr, rw);
        chk("b2b_rd10_data", 64'(rd), 64'h0000_F00D);

        r_hold = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h000;
        @(negedge clk);
        chk("to_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1 || i == 8) chk("timeout_low_wait", 64'(timeout_o), 64'd0);
            if (i == 9) chk("timeout_high", 64'(timeout_o), 64'd1);
        end
        repeat (3) begin
            @(negedge clk);
            chk("timeout_sticky", 64'({timeout_o, bus.rready, bus.arvalid}), 64'b110);
        end
        @(posedge clk); #1 r_hold = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!rsp_valid && k < 20);
        chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("timeout_in_rsp", 64'(timeout_o), 64'd1);
        @(posedge clk); @(negedge clk);
        chk("timeout_cleared", 64'({timeout_o, cmd_ready}), 64'b01);

        aw_delay = 50;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h014; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
        @(negedge clk);
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midwr_aw_pending", 64'({bus.awvalid, bus.bready}), 64'b11);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midwr_rst_valids", 64'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready,
                                      bus.rready, rsp_valid}), 64'd0);
        chk("midwr_rst_ready", 64'(cmd_ready), 64'd1);
        aw_delay = 0;
        @(posedge clk); #1 rst_n = 1'b1;

        run_cmd(1'b1, 12'h000, 32'h1122_3344, 4'hF, 0, lat, rd, rr, rw);
        run_cmd(1'b0, 12'h000, 32'h0, 4'h0, 0, lat, rd, rr, rw);
        chk("post_rst_rd0", 64'(rd), 64'h1122_3344);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
